tf_gen: RTL and testbench

TF_GEN -- requirements
Module: tf_gen

---
 rtl/tf_pkg.sv | 44 ++++
 rtl/tf_lane.sv | 132 +++++++++++++
 rtl/tf_gen.sv | 60 ++++++
 tb/tb_tf_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
// Shared types and helpers for the twiddle-factor generator: octant flags,
// the 45-degree constant and the octant fold/unfold helpers.
package tf_pkg;

    typedef struct packed {
        logic swap;
        logic neg_re;
        logic neg_im;
    } oct_flags_t;

    // floor(2^frac * sqrt(0.5)) == isqrt(2^(2*frac-1)), exact integer search
    function automatic longint unsigned c45(input int frac);
        longint unsigned target;
        longint unsigned root;
        longint unsigned cand;
        target = 64'd1 << (2 * frac - 1);
        root   = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            cand = root | (64'd1 << b);
            if (cand * cand <= target) begin
                root = cand;
            end else begin
                root = root;
            end
        end
        return root;
    endfunction

    function automatic logic [9:0] fold_t(input logic [2:0] o, input logic [9:0] r,
                                          input int log2n);
        logic [9:0] eighth;
        eighth = 10'd1 << (log2n - 3);
        return o[0] ? (eighth - r) : r;
    endfunction

    function automatic oct_flags_t oct_flags(input logic [2:0] o, input logic inv);
        oct_flags_t f;
        f.swap   = o[1] ^ o[0];
        f.neg_re = o[2] ^ o[1];
        f.neg_im = (~o[2]) ^ inv;
        return f;
    endfunction

endpackage

// File: rtl/tf_lane.sv
// One twiddle lane: octant fold, first-octant ROM with 45-degree bypass, unfold.
// Conjugation by inv is only built when TF_GEN_INV_EN is defined.
module tf_lane
    import tf_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int W     = 32,
    parameter int FRAC  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    input  logic [LOG2N-1:0]   k,
    input  logic               inv,
    output logic [2*W-1:0]     tf
);

    localparam int N   = 1 << LOG2N;
    localparam int OCT = N / 8;
    localparam int RW  = LOG2N - 3;
    localparam int TW  = LOG2N - 2;
    localparam int DW  = 2 * W;
    localparam logic signed [127:0] PI_Q60  = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] ONE_Q60 = 128'sh1000000000000000;

    // First-octant {cos, sin} magnitudes, truncated, computed at elaboration in Q60
    function automatic logic [OCT*DW-1:0] build_rom();
        logic [OCT*DW-1:0]   img;
        logic signed [127:0] th, th2, tc, ts, c, s;
        img = '0;
        for (int t = 0; t < OCT; t++) begin
            th  = (PI_Q60 * 128'(t)) >>> (LOG2N - 1);
            th2 = (th * th) >>> 60;
            tc  = ONE_Q60;
            ts  = th;
            c   = tc;
            s   = ts;
            for (int n = 1; n <= 12; n++) begin
                tc = -((tc * th2) >>> 60) / 128'(2 * n * (2 * n - 1));
                ts = -((ts * th2) >>> 60) / 128'(2 * n * (2 * n + 1));
                c  = c + tc;
                s  = s + ts;
            end
            c = c >>> (60 - FRAC);
            s = s >>> (60 - FRAC);
            img[t*DW +: DW] = {c[W-1:0], s[W-1:0]};
        end
        return img;
    endfunction

    localparam logic [OCT*DW-1:0] ROM_IMG = build_rom();
    localparam logic [W-1:0]      C45     = W'(c45(FRAC));

    logic [2:0]    o_s;
    logic [RW-1:0] r_s;
    logic [TW-1:0] t_s;
    logic [TW-1:0] t_r;
    logic [2:0]    o_r;
    logic          s1_inv_s;
    logic [DW-1:0] rom_word_s;
    logic [DW-1:0] d2_s;
    logic [DW-1:0] data_r;
    oct_flags_t    flags_r;
    logic [W-1:0]  cos_m_s, sin_m_s, re_m_s, im_m_s, re_s, im_s;

    // Fold the exponent into octant and first-octant index
    always_comb begin
        o_s = k[LOG2N-1 -: 3];
        r_s = k[RW-1:0];
        t_s = TW'(fold_t(o_s, 10'(r_s), LOG2N));
    end

`ifdef TF_GEN_INV_EN
    logic inv_r;

    // Inverse request travels with the vector through S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r <= 1'b0;
        end else if (adv) begin
            inv_r <= inv;
        end
    end
    assign s1_inv_s = inv_r;
`else
    logic unused_inv_s;
    assign unused_inv_s = inv;
    assign s1_inv_s     = 1'b0;
`endif

    // ROM lookup, replaced by the constant at exactly 45 degrees
    always_comb begin
        rom_word_s = ROM_IMG[32'(t_r[RW-1:0]) * DW +: DW];
        if (t_r == TW'(OCT)) begin
            d2_s = {C45, C45};
        end else begin
            d2_s = rom_word_s;
        end
    end

    // S1 (index, octant) and S2 (ROM data, flags); everything holds under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_r     <= '0;
            o_r     <= 3'd0;
            data_r  <= '0;
            flags_r <= '0;
        end else if (adv) begin
            t_r     <= t_s;
            o_r     <= o_s;
            data_r  <= d2_s;
            flags_r <= oct_flags(o_r, s1_inv_s);
        end
    end

    // Unfold: swap and sign-correct the first-octant magnitudes
    always_comb begin
        cos_m_s = data_r[DW-1:W];
        sin_m_s = data_r[W-1:0];
        if (flags_r.swap) begin
            re_m_s = sin_m_s;
            im_m_s = cos_m_s;
        end else begin
            re_m_s = cos_m_s;
            im_m_s = sin_m_s;
        end
        re_s = flags_r.neg_re ? -re_m_s : re_m_s;
        im_s = flags_r.neg_im ? -im_m_s : im_m_s;
        tf   = {re_s, im_s};
    end

endmodule

// File: rtl/tf_gen.sv
// Multi-lane twiddle-factor generator with a two-stage valid/ready pipeline.
// Optional macro TF_GEN_INV_EN enables in_inv (conjugated output).
module tf_gen
    import tf_pkg::*;
#(
    parameter int    LANES    = 4,
    parameter int    LOG2N    = 8,
    parameter int    W        = 32,
    parameter int    FRAC     = 16,
    parameter string ROM_FILE = "../TF.hex"
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LOG2N-1:0]   in_exp,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*2*W-1:0]     out_tf
);

    logic adv_s;
    logic s1_valid_r;
    logic s2_valid_r;
    // The table is computed at elaboration, so the external image name is not read
    logic unused_rom_file_s;

    assign unused_rom_file_s = (ROM_FILE != "");
    assign adv_s     = (~s2_valid_r) | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = s2_valid_r;

    // Slot valid bits; a bubble enters S1 whenever in_valid is low on advance
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            s2_valid_r <= s1_valid_r;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tf_lane #(
            .LOG2N (LOG2N),
            .W     (W),
            .FRAC  (FRAC)
        ) u_lane (
            .clk   (CLK),
            .rst_n (RSTn),
            .adv   (adv_s),
            .k     (in_exp[i*LOG2N +: LOG2N]),
            .inv   (in_inv),
            .tf    (out_tf[i*2*W +: 2*W])
        );
    end

endmodule

// File: tb/tb_tf_gen.sv
// Self-checking bench for tf_gen: reset, sanity, octants, inverse, sweep,
// backpressure and mid-stream reset against a trigonometric reference model.
module tb_tf_gen;

    localparam int LANES = 4;
    localparam int LOG2N = 8;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int N     = 1 << LOG2N;
    localparam int EW    = LANES * LOG2N;
    localparam int VW    = LANES * 2 * W;
`ifdef TF_GEN_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_exp;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_tf;

    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] exp_q[$];

    tf_gen #(.LANES(LANES), .LOG2N(LOG2N), .W(W), .FRAC(FRAC)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tf    (out_tf)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] model_tf(input int k, input logic inv);
        real ang;
        int  re_i, im_i;
        ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        re_i = $rtoi($cos(ang) * 65536.0);
        im_i = $rtoi(-$sin(ang) * 65536.0);
        if (INV_EN && inv) im_i = -im_i;
        return {32'(re_i), 32'(im_i)};
    endfunction

    function automatic logic [VW-1:0] model_vec(input logic [EW-1:0] e, input logic inv);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*64 +: 64] = model_tf(int'(e[i*LOG2N +: LOG2N]), inv);
        return v;
    endfunction

    task automatic test_reset;
        RSTn = 1'b0; in_valid = 1'b0; in_exp = '0; in_inv = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_tf !== '0) begin errors++; $display("FAIL reset_out_tf: got %h expected 0", out_tf); end
        RSTn = 1'b1;
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_sanity;
        logic [VW-1:0] want;
        want = {LANES{32'h0001_0000, 32'h0000_0000}};
        @(negedge CLK);
        in_valid = 1'b1; in_exp = '0; in_inv = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sanity_ready: got %b expected 1", in_ready); end
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sanity_early: got %b expected 0", out_valid); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sanity_latency: got %b expected 1", out_valid); end
        checks++; if (out_tf !== want) begin errors++; $display("FAIL sanity_data: got %h expected %h", out_tf, want); end
        @(negedge CLK);
    endtask

    task automatic test_octants;
        logic [31:0] re_c[LANES];
        logic [31:0] im_c[LANES];
        re_c = '{32'h0000_B504, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000};
        im_c = '{32'hFFFF_4AFC, 32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000};
        @(negedge CLK);
        in_valid = 1'b1; in_exp = {8'd192, 8'd128, 8'd64, 8'd32}; in_inv = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < LANES; i++) begin
            checks++; if (out_tf[i*64+32 +: 32] !== re_c[i]) begin errors++; $display("FAIL octant_re lane %0d: got %h expected %h", i, out_tf[i*64+32 +: 32], re_c[i]); end
            checks++; if (out_tf[i*64 +: 32] !== im_c[i]) begin errors++; $display("FAIL octant_im lane %0d: got %h expected %h", i, out_tf[i*64 +: 32], im_c[i]); end
        end
        checks++; if (out_tf !== model_vec({8'd192, 8'd128, 8'd64, 8'd32}, 1'b0)) begin errors++; $display("FAIL octant_model: got %h", out_tf); end
        @(negedge CLK);
    endtask

    task automatic test_inverse;
        logic [31:0] want_im;
        want_im = INV_EN ? 32'h0001_0000 : 32'hFFFF_0000;
        @(negedge CLK);
        in_valid = 1'b1; in_exp = {LANES{8'd64}}; in_inv = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0; in_inv = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < LANES; i++) begin
            checks++; if (out_tf[i*64 +: 32] !== want_im || out_tf[i*64+32 +: 32] !== 32'h0) begin errors++; $display("FAIL inverse lane %0d: got %h expected 00000000%h", i, out_tf[i*64 +: 64], want_im); end
        end
        @(negedge CLK);
    endtask

    task automatic test_sweep;
        logic [EW-1:0] e;
        logic [VW-1:0] want;
        int run, max_run, seen, not_ready;
        run = 0; max_run = 0; seen = 0; not_ready = 0;
        exp_q.delete();
        for (int c = 0; c < N + 8; c++) begin
            @(negedge CLK);
            e = EW'($urandom);
            if (c < N) begin
                e[LOG2N-1:0] = c[LOG2N-1:0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            in_exp = e; in_inv = 1'($urandom % 2); out_ready = 1'b1;
            #1;
            if (out_valid === 1'b1) begin
                run++; seen++;
                if (run > max_run) max_run = run;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL sweep_extra: got %h expected no vector", out_tf); end
                else begin
                    want = exp_q.pop_front();
                    if (out_tf !== want) begin errors++; $display("FAIL sweep_data: got %h expected %h", out_tf, want); end
                end
            end else begin
                run = 0;
            end
            if (in_valid && in_ready !== 1'b1) not_ready++;
            if (in_valid && in_ready === 1'b1) exp_q.push_back(model_vec(in_exp, in_inv));
        end
        checks++; if (seen != N) begin errors++; $display("FAIL sweep_count: got %0d expected %0d", seen, N); end
        checks++; if (max_run != N) begin errors++; $display("FAIL sweep_consecutive: got %0d expected %0d", max_run, N); end
        checks++; if (not_ready != 0) begin errors++; $display("FAIL sweep_in_ready: got %0d stalls expected 0", not_ready); end
    endtask

    task automatic test_backpressure;
        logic [VW-1:0] held, want;
        exp_q.delete();
        held = '0;
        for (int c = 0; c < 170; c++) begin
            @(negedge CLK);
            if (c < 5) begin
                in_valid = 1'b1; out_ready = 1'b0;
            end else if (c < 155) begin
                in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 3) != 0;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            in_exp = EW'($urandom); in_inv = 1'($urandom % 2);
            #1;
            if (c == 2) held = out_tf;
            if (c >= 2 && c < 5) begin
                checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_flags cycle %0d: got r=%b v=%b expected r=0 v=1", c, in_ready, out_valid); end
                checks++; if (out_tf !== held) begin errors++; $display("FAIL stall_hold cycle %0d: got %h expected %h", c, out_tf, held); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_duplicate: got %h expected no vector", out_tf); end
                else begin
                    want = exp_q.pop_front();
                    if (out_tf !== want) begin errors++; $display("FAIL bp_data: got %h expected %h", out_tf, want); end
                end
            end
            if (in_valid && in_ready === 1'b1) exp_q.push_back(model_vec(in_exp, in_inv));
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost: got %0d undelivered expected 0", exp_q.size()); end
    endtask

    task automatic test_midreset;
        @(negedge CLK);
        in_valid = 1'b1; in_exp = EW'($urandom); in_inv = 1'b0; out_ready = 1'b0;
        @(negedge CLK);
        in_exp = EW'($urandom);
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight: got %b expected 1", out_valid); end
        #1 RSTn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++; if (out_tf !== '0) begin errors++; $display("FAIL midrst_tf: got %h expected 0", out_tf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
        @(negedge CLK);
        RSTn = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %b expected 0", out_valid); end
        in_valid = 1'b1; in_exp = '0;
        @(negedge CLK);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b expected 0", out_valid); end
        @(negedge CLK);
        checks++; if (out_valid !== 1'b1 || out_tf !== model_vec('0, 1'b0)) begin errors++; $display("FAIL midrst_first: got v=%b %h expected v=1 %h", out_valid, out_tf, model_vec('0, 1'b0)); end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_sanity();
        test_octants();
        test_inverse();
        test_sweep();
        test_backpressure();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
